// File: rtl/pipe_ctrl_pkg.sv
// Shared core package: stage indices, datapath widths, MD encoding
// and the per-cycle sequencing action chosen by pipe_ctrl.
package pipe_ctrl_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RAW_DEF  = 5;

    localparam int ST_IF = 0;
    localparam int ST_ID = 1;
    localparam int ST_EX = 2;

    typedef enum logic [1:0] {
        MD_ALU = 2'b00,
        MD_MEM = 2'b01,
        MD_PC  = 2'b10
    } md_e;

    localparam md_e MD_LOAD = MD_MEM;

    typedef enum logic [1:0] {
        ACT_RUN,
        ACT_WAIT,
        ACT_STALL,
        ACT_REDIR
    } act_e;

    // Redirect beats load-use, which beats a fetch wait-state.
    function automatic act_e pick_act(
        input logic re,
        input logic lu,
        input logic rdy
    );
        if (re) begin
            return ACT_REDIR;
        end
        if (lu) begin
            return ACT_STALL;
        end
        if (!rdy) begin
            return ACT_WAIT;
        end
        return ACT_RUN;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational hazard logic: load-use detect and EX->ID forward
// selects. Holds no state; pipe_ctrl supplies the stage valids.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int RAW = RAW_DEF
) (
    input  logic           id_vld,
    input  logic           ex_vld,
    input  logic           redir_eff,
    input  logic [RAW-1:0] id_aa,
    input  logic [RAW-1:0] id_ba,
    input  logic           id_ua,
    input  logic           id_ub,
    input  logic [RAW-1:0] ex_da,
    input  logic           ex_rw,
    input  logic           ex_ld,
    output logic           lu,
    output logic           ha,
    output logic           hb
);

    logic a_hit;
    logic b_hit;
    logic lu_raw;

    // R0 is never a dependency; a redirect masks every hazard output.
    always_comb begin
        a_hit  = id_ua & (id_aa == ex_da) & (ex_da != '0);
        b_hit  = id_ub & (id_ba == ex_da) & (ex_da != '0);
        lu_raw = id_vld & ex_vld & ex_ld & ex_rw & (a_hit | b_hit);
        lu     = lu_raw & ~redir_eff;
        ha     = a_hit & ex_vld & ex_rw & ~ex_ld & ~lu_raw & ~redir_eff;
        hb     = b_hit & ex_vld & ex_rw & ~ex_ld & ~lu_raw & ~redir_eff;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing: fetch PC, per-stage PC/valid, stall and flush.
// Optional performance counters are built when PERF_CNT_EN is defined.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              NSTAGE   = 5,
    parameter int              RAW      = RAW_DEF,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   imem_ready,
    input  logic [RAW-1:0]         id_aa,
    input  logic [RAW-1:0]         id_ba,
    input  logic                   id_ua,
    input  logic                   id_ub,
    input  logic [RAW-1:0]         ex_da,
    input  logic                   ex_rw,
    input  logic                   ex_ld,
    input  logic                   redir,
    input  logic [XLEN-1:0]        redir_pc,
    output logic [XLEN-1:0]        pc,
    output logic [NSTAGE*XLEN-1:0] stage_pc,
    output logic [NSTAGE-1:0]      stage_vld,
    output logic                   stall,
    output logic                   flush,
    output logic                   ha,
    output logic                   hb
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]            cnt_cyc,
    output logic [31:0]            cnt_stall,
    output logic [31:0]            cnt_flush
`endif
);

    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   pc_d;
    logic [XLEN-1:0]   spc_q [1:NSTAGE-1];
    logic [XLEN-1:0]   spc_d [1:NSTAGE-1];
    logic [NSTAGE-1:1] vld_q;
    logic [NSTAGE-1:1] vld_d;

    logic redir_eff;
    logic lu;
    act_e act;

    assign redir_eff = redir & vld_q[ST_EX];

    hazard_detect #(
        .RAW (RAW)
    ) u_hz (
        .id_vld    (vld_q[ST_ID]),
        .ex_vld    (vld_q[ST_EX]),
        .redir_eff (redir_eff),
        .id_aa     (id_aa),
        .id_ba     (id_ba),
        .id_ua     (id_ua),
        .id_ub     (id_ub),
        .ex_da     (ex_da),
        .ex_rw     (ex_rw),
        .ex_ld     (ex_ld),
        .lu        (lu),
        .ha        (ha),
        .hb        (hb)
    );

    assign act   = pick_act(redir_eff, lu, imem_ready);
    assign stall = lu;
    assign flush = redir_eff;

    // Next PC and stage contents; stages past EX always shift.
    always_comb begin
        pc_d  = pc_q;
        vld_d = vld_q;
        for (int k = 1; k < NSTAGE; k++) begin
            spc_d[k] = spc_q[k];
        end
        for (int k = NSTAGE - 1; k > ST_EX; k--) begin
            spc_d[k] = spc_q[k-1];
            vld_d[k] = vld_q[k-1];
        end
        unique case (act)
            ACT_REDIR: begin
                pc_d         = redir_pc;
                spc_d[ST_ID] = '0;
                vld_d[ST_ID] = 1'b0;
                spc_d[ST_EX] = '0;
                vld_d[ST_EX] = 1'b0;
            end
            ACT_STALL: begin
                spc_d[ST_EX] = '0;
                vld_d[ST_EX] = 1'b0;
            end
            ACT_WAIT: begin
                spc_d[ST_EX] = spc_q[ST_ID];
                vld_d[ST_EX] = vld_q[ST_ID];
                spc_d[ST_ID] = '0;
                vld_d[ST_ID] = 1'b0;
            end
            ACT_RUN: begin
                pc_d         = pc_q + {{(XLEN-1){1'b0}}, 1'b1};
                spc_d[ST_EX] = spc_q[ST_ID];
                vld_d[ST_EX] = vld_q[ST_ID];
                spc_d[ST_ID] = pc_q;
                vld_d[ST_ID] = 1'b1;
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

    // State register; reset drops any pending stall or redirect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            vld_q <= '0;
            for (int k = 1; k < NSTAGE; k++) begin
                spc_q[k] <= '0;
            end
        end else begin
            pc_q  <= pc_d;
            vld_q <= vld_d;
            for (int k = 1; k < NSTAGE; k++) begin
                spc_q[k] <= spc_d[k];
            end
        end
    end

    // Flatten per-stage PCs; slot 0 mirrors the fetch PC.
    always_comb begin
        stage_pc = '0;
        stage_pc[ST_IF*XLEN +: XLEN] = pc_q;
        for (int k = 1; k < NSTAGE; k++) begin
            stage_pc[k*XLEN +: XLEN] = spc_q[k];
        end
    end

    assign pc        = pc_q;
    assign stage_vld = {vld_q, imem_ready & ~redir_eff};

`ifdef PERF_CNT_EN
    logic [31:0] cyc_q;
    logic [31:0] stl_q;
    logic [31:0] fls_q;

    // Saturating cycle, stall and flush counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_q <= '0;
            stl_q <= '0;
            fls_q <= '0;
        end else begin
            cyc_q <= sat_inc(cyc_q);
            if (stall) begin
                stl_q <= sat_inc(stl_q);
            end
            if (flush) begin
                fls_q <= sat_inc(fls_q);
            end
        end
    end

    assign cnt_cyc   = cyc_q;
    assign cnt_stall = stl_q;
    assign cnt_flush = fls_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: reference model feeding a
// scoreboard queue, plus scenario checks of the documented cases.
module tb_pipe_ctrl;

    localparam int XLEN   = 32;
    localparam int NSTAGE = 5;
    localparam int RAW    = 5;
    localparam logic [XLEN-1:0] RESET_PC = '0;

    logic clk = 1'b0;
    logic rst_n;
    logic imem_ready;
    logic [RAW-1:0] id_aa;
    logic [RAW-1:0] id_ba;
    logic id_ua;
    logic id_ub;
    logic [RAW-1:0] ex_da;
    logic ex_rw;
    logic ex_ld;
    logic redir;
    logic [XLEN-1:0] redir_pc;
    logic [XLEN-1:0] pc;
    logic [NSTAGE*XLEN-1:0] stage_pc;
    logic [NSTAGE-1:0] stage_vld;
    logic stall;
    logic flush;
    logic ha;
    logic hb;
`ifdef PERF_CNT_EN
    logic [31:0] cnt_cyc;
    logic [31:0] cnt_stall;
    logic [31:0] cnt_flush;
`endif

    pipe_ctrl #(
        .XLEN     (XLEN),
        .NSTAGE   (NSTAGE),
        .RAW      (RAW),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_ready (imem_ready),
        .id_aa      (id_aa),
        .id_ba      (id_ba),
        .id_ua      (id_ua),
        .id_ub      (id_ub),
        .ex_da      (ex_da),
        .ex_rw      (ex_rw),
        .ex_ld      (ex_ld),
        .redir      (redir),
        .redir_pc   (redir_pc),
        .pc         (pc),
        .stage_pc   (stage_pc),
        .stage_vld  (stage_vld),
        .stall      (stall),
        .flush      (flush),
        .ha         (ha),
        .hb         (hb)
`ifdef PERF_CNT_EN
        ,
        .cnt_cyc    (cnt_cyc),
        .cnt_stall  (cnt_stall),
        .cnt_flush  (cnt_flush)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [XLEN-1:0]        pc;
        logic [NSTAGE-1:1]      vld;
        logic [NSTAGE*XLEN-1:0] spc;
        logic [31:0]            cyc;
        logic [31:0]            stl;
        logic [31:0]            fls;
    } exp_t;

    exp_t sb[$];

    logic [XLEN-1:0]   m_pc;
    logic [XLEN-1:0]   m_spc [NSTAGE];
    logic [NSTAGE-1:1] m_vld;
    logic [31:0]       m_cyc;
    logic [31:0]       m_stl;
    logic [31:0]       m_fls;
    bit                m_init = 1'b0;

    logic s_stall;
    logic s_flush;
    logic s_ha;
    logic s_hb;

    task automatic idle();
        imem_ready = 1'b1;
        id_aa = '0;
        id_ba = '0;
        id_ua = 1'b0;
        id_ub = 1'b0;
        ex_da = '0;
        ex_rw = 1'b0;
        ex_ld = 1'b0;
        redir = 1'b0;
        redir_pc = '0;
    endtask

    // One clock: check combinational outputs, predict, then compare state.
    task automatic step();
        logic re;
        logic a_hit;
        logic b_hit;
        logic lu_e;
        logic ha_e;
        logic hb_e;
        exp_t e;
        exp_t got;
        @(negedge clk);
        s_stall = stall;
        s_flush = flush;
        s_ha    = ha;
        s_hb    = hb;
        re    = redir & m_vld[2];
        a_hit = id_ua && (id_aa == ex_da) && (ex_da != 0);
        b_hit = id_ub && (id_ba == ex_da) && (ex_da != 0);
        lu_e  = m_vld[1] & m_vld[2] & ex_ld & ex_rw & (a_hit | b_hit) & ~re;
        ha_e  = a_hit & m_vld[2] & ex_rw & ~ex_ld & ~re;
        hb_e  = b_hit & m_vld[2] & ex_rw & ~ex_ld & ~re;
        if (m_init) begin
            checks++;
            if (stall !== lu_e) begin
                errors++;
                $display("FAIL stall: got %b want %b", stall, lu_e);
            end
            checks++;
            if (flush !== re) begin
                errors++;
                $display("FAIL flush: got %b want %b", flush, re);
            end
            checks++;
            if ({ha, hb} !== {ha_e, hb_e}) begin
                errors++;
                $display("FAIL fwd: got ha/hb %b%b want %b%b", ha, hb, ha_e, hb_e);
            end
            checks++;
            if (stage_vld[0] !== (imem_ready & ~re)) begin
                errors++;
                $display("FAIL vld0: got %b want %b", stage_vld[0], imem_ready & ~re);
            end
        end
        if (!rst_n) begin
            m_pc  = RESET_PC;
            m_vld = '0;
            for (int k = 0; k < NSTAGE; k++) m_spc[k] = '0;
            m_cyc = '0;
            m_stl = '0;
            m_fls = '0;
            m_init = 1'b1;
        end else begin
            for (int k = NSTAGE - 1; k >= 3; k--) begin
                m_spc[k] = m_spc[k-1];
                m_vld[k] = m_vld[k-1];
            end
            if (re) begin
                m_pc = redir_pc;
                m_spc[1] = '0;
                m_vld[1] = 1'b0;
                m_spc[2] = '0;
                m_vld[2] = 1'b0;
                if (m_fls != 32'hFFFF_FFFF) m_fls++;
            end else if (lu_e) begin
                m_spc[2] = '0;
                m_vld[2] = 1'b0;
                if (m_stl != 32'hFFFF_FFFF) m_stl++;
            end else if (!imem_ready) begin
                m_spc[2] = m_spc[1];
                m_vld[2] = m_vld[1];
                m_spc[1] = '0;
                m_vld[1] = 1'b0;
            end else begin
                m_spc[2] = m_spc[1];
                m_vld[2] = m_vld[1];
                m_spc[1] = m_pc;
                m_vld[1] = 1'b1;
                m_pc = m_pc + 1;
            end
            if (m_cyc != 32'hFFFF_FFFF) m_cyc++;
        end
        e.pc  = m_pc;
        e.vld = m_vld;
        e.spc = '0;
        e.spc[0 +: XLEN] = m_pc;
        for (int k = 1; k < NSTAGE; k++) e.spc[k*XLEN +: XLEN] = m_spc[k];
        e.cyc = m_cyc;
        e.stl = m_stl;
        e.fls = m_fls;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: got empty queue want 1 entry");
        end else begin
            got = sb.pop_front();
            if (pc !== got.pc) begin
                errors++;
                $display("FAIL pc: got %h want %h", pc, got.pc);
            end
            checks++;
            if (stage_vld[NSTAGE-1:1] !== got.vld) begin
                errors++;
                $display("FAIL stage_vld: got %b want %b", stage_vld[NSTAGE-1:1], got.vld);
            end
            checks++;
            if (stage_pc !== got.spc) begin
                errors++;
                $display("FAIL stage_pc: got %h want %h", stage_pc, got.spc);
            end
`ifdef PERF_CNT_EN
            checks++;
            if ({cnt_cyc, cnt_stall, cnt_flush} !== {got.cyc, got.stl, got.fls}) begin
                errors++;
                $display("FAIL counters: got %0d/%0d/%0d want %0d/%0d/%0d",
                         cnt_cyc, cnt_stall, cnt_flush, got.cyc, got.stl, got.fls);
            end
`endif
        end
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        step();
        checks++;
        if (pc !== RESET_PC) begin
            errors++;
            $display("FAIL reset_pc: got %h want %h", pc, RESET_PC);
        end
        checks++;
        if (stage_vld !== 5'b00001) begin
            errors++;
            $display("FAIL reset_vld: got %b want 00001", stage_vld);
        end
        checks++;
        if ({stall, flush} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ctl: got stall/flush %b%b want 00", stall, flush);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_straight();
        logic [4:0] vt [4];
        vt = '{5'b00011, 5'b00111, 5'b01111, 5'b11111};
        idle();
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (pc !== XLEN'(i + 1)) begin
                errors++;
                $display("FAIL straight_pc: got %0d want %0d", pc, i + 1);
            end
            checks++;
            if (stage_vld !== vt[i]) begin
                errors++;
                $display("FAIL straight_vld: got %b want %b", stage_vld, vt[i]);
            end
            if (i == 1) begin
                checks++;
                if (stage_pc[2*XLEN +: XLEN] !== '0) begin
                    errors++;
                    $display("FAIL straight_ex_pc: got %h want 0", stage_pc[2*XLEN +: XLEN]);
                end
            end
        end
    endtask

    task automatic test_load_use();
        idle();
        ex_ld = 1'b1;
        ex_rw = 1'b1;
        ex_da = 5'd3;
        id_aa = 5'd3;
        id_ua = 1'b1;
        step();
        checks++;
        if (s_stall !== 1'b1) begin
            errors++;
            $display("FAIL lu_stall: got %b want 1", s_stall);
        end
        checks++;
        if (pc !== 32'd4 || stage_pc[XLEN +: XLEN] !== 32'd3) begin
            errors++;
            $display("FAIL lu_hold: got pc %0d id %0d want 4 3", pc, stage_pc[XLEN +: XLEN]);
        end
        checks++;
        if (stage_vld[2:1] !== 2'b01) begin
            errors++;
            $display("FAIL lu_bubble: got %b want 01", stage_vld[2:1]);
        end
        idle();
        step();
        checks++;
        if (s_stall !== 1'b0 || pc !== 32'd5) begin
            errors++;
            $display("FAIL lu_release: got stall %b pc %0d want 0 5", s_stall, pc);
        end
`ifdef PERF_CNT_EN
        checks++;
        if (cnt_stall !== 32'd1) begin
            errors++;
            $display("FAIL lu_cnt: got %0d want 1", cnt_stall);
        end
`endif
    endtask

    task automatic test_forward();
        idle();
        ex_da = 5'd4;
        ex_rw = 1'b1;
        id_ba = 5'd4;
        id_ub = 1'b1;
        step();
        checks++;
        if ({s_ha, s_hb, s_stall} !== 3'b010) begin
            errors++;
            $display("FAIL fwd_b: got ha/hb/stall %b%b%b want 010", s_ha, s_hb, s_stall);
        end
        ex_da = 5'd0;
        id_ba = 5'd0;
        step();
        checks++;
        if (s_hb !== 1'b0) begin
            errors++;
            $display("FAIL fwd_r0: got hb %b want 0", s_hb);
        end
        idle();
        ex_da = 5'd7;
        ex_rw = 1'b1;
        id_aa = 5'd7;
        id_ua = 1'b1;
        step();
        checks++;
        if ({s_ha, s_hb} !== 2'b10) begin
            errors++;
            $display("FAIL fwd_a: got ha/hb %b%b want 10", s_ha, s_hb);
        end
    endtask

    task automatic test_redirect();
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) step();
        redir = 1'b1;
        redir_pc = 32'h40;
        step();
        checks++;
        if ({s_flush, s_stall} !== 2'b10) begin
            errors++;
            $display("FAIL redir_ctl: got flush/stall %b%b want 10", s_flush, s_stall);
        end
        checks++;
        if (pc !== 32'h40 || stage_vld[3:1] !== 3'b100) begin
            errors++;
            $display("FAIL redir_state: got pc %h vld %b want 40 100", pc, stage_vld[3:1]);
        end
        checks++;
        if (stage_pc[3*XLEN +: XLEN] !== 32'd5) begin
            errors++;
            $display("FAIL redir_ex_adv: got %0d want 5", stage_pc[3*XLEN +: XLEN]);
        end
        redir_pc = 32'h80;
        step();
        checks++;
        if (s_flush !== 1'b0 || pc !== 32'h41) begin
            errors++;
            $display("FAIL redir_bubble: got flush %b pc %h want 0 41", s_flush, pc);
        end
        idle();
    endtask

    task automatic test_redir_lu();
        idle();
        step();
        redir = 1'b1;
        redir_pc = 32'h100;
        ex_ld = 1'b1;
        ex_rw = 1'b1;
        ex_da = 5'd3;
        id_aa = 5'd3;
        id_ua = 1'b1;
        step();
        checks++;
        if ({s_flush, s_stall} !== 2'b10 || pc !== 32'h100) begin
            errors++;
            $display("FAIL redir_lu: got flush/stall %b%b pc %h want 10 100", s_flush, s_stall, pc);
        end
`ifdef PERF_CNT_EN
        checks++;
        if (cnt_stall !== 32'd0 || cnt_flush !== 32'd2) begin
            errors++;
            $display("FAIL redir_lu_cnt: got %0d/%0d want 0/2", cnt_stall, cnt_flush);
        end
`endif
        idle();
    endtask

    task automatic test_wait_reset();
        idle();
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (pc !== 32'h100 || stage_vld[1] !== 1'b0) begin
                errors++;
                $display("FAIL wait: got pc %h id_vld %b want 100 0", pc, stage_vld[1]);
            end
        end
        checks++;
        if (stage_vld[3:1] !== 3'b000) begin
            errors++;
            $display("FAIL wait_bubbles: got %b want 000", stage_vld[3:1]);
        end
        imem_ready = 1'b1;
        redir = 1'b1;
        redir_pc = 32'h99;
        rst_n = 1'b0;
        step();
        checks++;
        if (pc !== RESET_PC || stage_vld[NSTAGE-1:1] !== '0) begin
            errors++;
            $display("FAIL mid_reset: got pc %h vld %b want 0 0", pc, stage_vld);
        end
        rst_n = 1'b1;
        idle();
        step();
        checks++;
        if (pc !== 32'd1 || stage_vld[1] !== 1'b1 || stage_pc[XLEN +: XLEN] !== RESET_PC) begin
            errors++;
            $display("FAIL first_fetch: got pc %h id %h/%b want 1 0/1",
                     pc, stage_pc[XLEN +: XLEN], stage_vld[1]);
        end
    endtask

    initial begin
        test_reset();
        test_straight();
        test_load_use();
        test_forward();
        test_redirect();
        test_redir_lu();
        test_wait_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
